// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV instruction-fetch front end.
package rv_fetch_pkg;

  localparam int INST_W  = 32;
  localparam int PC_W    = 32;
  localparam int PC_STEP = 4;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_queue_fifo.sv
// Show-ahead FIFO of fetch entries; the head entry is visible combinationally
// from storage, and a push into a full FIFO is accepted when a pop frees a slot.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int              DEPTH  = 4,
  parameter logic [PC_W-1:0] RST_PC = 32'h0000_0000,
  localparam int             AW     = $clog2(DEPTH),
  localparam int             CW     = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic         empty_o,
  output logic         full_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify push/pop against current occupancy.
  always_comb begin
    do_pop_s  = pop_i && (cnt_q != '0);
    do_push_s = push_i && ((cnt_q != CW'(DEPTH)) || do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: RST_PC, inst: '0};
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/rv_fetch_queue.sv
// Instruction-fetch front end: sequential request issue with bounded
// outstanding requests, redirect flush with stale-response draining.
module rv_fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] PC_RESET  = 32'h0000_0000,
  parameter int                DEPTH     = 4,
  parameter int                MAX_OUTST = 2,
  localparam int               CW        = $clog2(DEPTH + 1),
  localparam int               OW        = $clog2(MAX_OUTST + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_req_valid,
  output logic [ADDR_W-1:0] o_req_addr,
  input  logic              i_req_ready,
  input  logic              i_rsp_valid,
  input  logic [INST_W-1:0] i_rsp_inst,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_stall,
  output logic              o_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic [CW-1:0]     o_count,
  output logic              o_rsp_err
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [OW-1:0]     drop_q, drop_d;
  logic              err_q, err_d;

  logic [OW-1:0]     live_s;
  logic              issue_ok_s;
  logic              fire_s;
  logic              rsp_ok_s;
  logic              rsp_stale_s;
  logic              push_s;
  logic              pop_s;
  fetch_entry_t      din_s;
  fetch_entry_t      head_s;
  logic [CW-1:0]     count_s;
  logic              empty_s;
  logic              full_s;

  // Issue control, response classification and next-state for counters/PCs.
  always_comb begin
    live_s      = outst_q - drop_q;
    // Only issue when every live response already has a guaranteed queue slot.
    issue_ok_s  = i_rst_n && (outst_q < OW'(MAX_OUTST)) && !full_s &&
                  ((int'(count_s) + int'(live_s)) < DEPTH) && !i_redirect;
    fire_s      = issue_ok_s && i_req_ready;
    rsp_ok_s    = i_rsp_valid && (outst_q != '0);
    rsp_stale_s = rsp_ok_s && (state_q == DRAIN);
    push_s      = rsp_ok_s && !rsp_stale_s && !i_redirect;
    pop_s       = !empty_s && !i_stall && !i_redirect;
    din_s       = '{pc: PC_W'(rsp_pc_q), inst: i_rsp_inst};
    outst_d     = outst_q + OW'(fire_s) - OW'(rsp_ok_s);
    err_d       = err_q || (i_rsp_valid && (outst_q == '0));
    if (i_redirect) begin
      drop_d     = outst_q - OW'(rsp_ok_s);
      fetch_pc_d = i_redirect_pc;
      rsp_pc_d   = i_redirect_pc;
    end else begin
      drop_d     = rsp_stale_s ? (drop_q - OW'(1)) : drop_q;
      fetch_pc_d = fire_s ? (fetch_pc_q + ADDR_W'(PC_STEP)) : fetch_pc_q;
      rsp_pc_d   = push_s ? (rsp_pc_q + ADDR_W'(PC_STEP)) : rsp_pc_q;
    end
  end

  // Request/response counters, fetch and response PCs, sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc_q <= PC_RESET;
      rsp_pc_q   <= PC_RESET;
      outst_q    <= '0;
      drop_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  // RUN/DRAIN state machine: DRAIN while stale responses remain in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     state_q <= (i_redirect && (drop_d != '0)) ? DRAIN : RUN;
        DRAIN:   state_q <= (drop_d == '0) ? RUN : DRAIN;
        default: state_q <= RUN;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .RST_PC (PC_W'(PC_RESET))
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clear_i (i_redirect),
    .push_i  (push_s),
    .data_i  (din_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .count_o (count_s),
    .empty_o (empty_s),
    .full_o  (full_s)
  );

  assign o_req_valid = issue_ok_s;
  assign o_req_addr  = fetch_pc_q;
  assign o_valid     = !empty_s;
  assign o_inst      = head_s.inst;
  assign o_pc        = ADDR_W'(head_s.pc);
  assign o_count     = count_s;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Randomised bench for rv_fetch_queue against a queue-based reference model
// with a variable-latency in-order memory.
module tb_rv_fetch_queue;

  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] PC_RESET  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_req_valid;
  logic [31:0] o_req_addr;
  logic        i_req_ready;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_inst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_stall;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [2:0]  o_count;
  logic        o_rsp_err;

  always #5 clk = ~clk;

  rv_fetch_queue #(
    .ADDR_W    (32),
    .PC_RESET  (PC_RESET),
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_req_valid   (o_req_valid),
    .o_req_addr    (o_req_addr),
    .i_req_ready   (i_req_ready),
    .i_rsp_valid   (i_rsp_valid),
    .i_rsp_inst    (i_rsp_inst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_stall       (i_stall),
    .o_valid       (o_valid),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .o_count       (o_count),
    .o_rsp_err     (o_rsp_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    int          due;
    logic [31:0] inst;
  } mreq_t;

  ent_t        m_q[$];
  mreq_t       mem_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_rsp_pc;
  int          m_outst;
  int          m_drop;
  bit          m_err;
  int          cyc = 0;

  int n_vec = 0;
  int n_err = 0;

  int k_ready     = 100;
  int k_stall     = 0;
  int k_redir     = 0;
  int k_lat_min   = 1;
  int k_lat_max   = 1;
  bit k_spur      = 1'b0;
  bit k_redir_rsp = 1'b0;
  bit k_redir_fix = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_fetch_pc = PC_RESET;
    m_rsp_pc   = PC_RESET;
    m_outst    = 0;
    m_drop     = 0;
    m_err      = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n       = 1'b0;
    i_rsp_valid = 1'b0;
    i_redirect  = 1'b0;
    i_stall     = 1'b0;
    i_req_ready = 1'b0;
    model_reset();
    #1;
    check_val("rst_req_valid", {31'd0, o_req_valid}, 32'd0);
    check_val("rst_req_addr", o_req_addr, PC_RESET);
    check_val("rst_valid", {31'd0, o_valid}, 32'd0);
    check_val("rst_inst", o_inst, 32'd0);
    check_val("rst_pc", o_pc, PC_RESET);
    check_val("rst_count", {29'd0, o_count}, 32'd0);
    check_val("rst_err", {31'd0, o_rsp_err}, 32'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("first_req_valid", {31'd0, o_req_valid}, 32'd1);
    check_val("first_req_addr", o_req_addr, PC_RESET);
  endtask

  task automatic step();
    bit          rsp_v;
    bit          from_mem;
    bit          exp_rv;
    bit          fire;
    bit          rsp_ok;
    logic [31:0] rsp_inst;
    logic [31:0] old_pc;
    @(negedge clk);
    i_req_ready = pct(k_ready);
    i_stall     = pct(k_stall);
    rsp_v       = 1'b0;
    from_mem    = 1'b0;
    rsp_inst    = $urandom;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp_v    = 1'b1;
      from_mem = 1'b1;
      rsp_inst = mem_q[0].inst;
    end else if (k_spur && mem_q.size() == 0) begin
      rsp_v = 1'b1;
    end
    i_rsp_valid = rsp_v;
    i_rsp_inst  = rsp_inst;
    i_redirect  = pct(k_redir) || (k_redir_rsp && rsp_v);
    if (k_redir_fix) begin
      i_redirect_pc = 32'h0000_0100;
    end else begin
      case ($urandom_range(3))
        0:       i_redirect_pc = 32'h0000_0100;
        1:       i_redirect_pc = 32'hFFFF_FFF8;
        default: i_redirect_pc = $urandom & 32'hFFFF_FFFC;
      endcase
    end
    #1;
    exp_rv = (m_outst < MAX_OUTST) && ((m_q.size() + m_outst - m_drop) < DEPTH) && !i_redirect;
    check_val("req_valid", {31'd0, o_req_valid}, {31'd0, exp_rv});
    check_val("req_addr", o_req_addr, m_fetch_pc);
    check_val("valid", {31'd0, o_valid}, {31'd0, (m_q.size() > 0)});
    check_val("count", {29'd0, o_count}, m_q.size());
    check_val("rsp_err", {31'd0, o_rsp_err}, {31'd0, m_err});
    if (m_q.size() > 0) begin
      check_val("head_pc", o_pc, m_q[0].pc);
      check_val("head_inst", o_inst, m_q[0].inst);
    end
    fire   = exp_rv && i_req_ready;
    old_pc = m_fetch_pc;
    @(posedge clk);
    rsp_ok = rsp_v && (m_outst > 0);
    if (rsp_v && m_outst == 0) m_err = 1'b1;
    if (i_redirect) begin
      m_q.delete();
      m_drop     = m_outst - (rsp_ok ? 1 : 0);
      m_outst    = m_drop;
      m_fetch_pc = i_redirect_pc;
      m_rsp_pc   = i_redirect_pc;
    end else begin
      if (m_q.size() > 0 && !i_stall) void'(m_q.pop_front());
      if (rsp_ok) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          m_q.push_back('{pc: m_rsp_pc, inst: rsp_inst});
          m_rsp_pc = m_rsp_pc + 32'd4;
        end
      end
      m_outst = m_outst + (fire ? 1 : 0) - (rsp_ok ? 1 : 0);
      if (fire) m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (from_mem) void'(mem_q.pop_front());
    if (fire) mem_q.push_back('{due: cyc + int'($urandom_range(k_lat_max, k_lat_min)), inst: mem_word(old_pc)});
    cyc++;
  endtask

  initial begin
    rst_n         = 1'b0;
    i_req_ready   = 1'b0;
    i_rsp_valid   = 1'b0;
    i_rsp_inst    = 32'd0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'd0;
    i_stall       = 1'b0;
    model_reset();
    do_reset(2);

    // Streaming: ready always, 1-cycle latency, no stall.
    repeat (20) step();

    // Decode stall fills the queue, then releases.
    k_stall = 100;
    repeat (12) step();
    #1;
    check_val("stall_full_count", {29'd0, o_count}, DEPTH);
    check_val("stall_no_req", {31'd0, o_req_valid}, 32'd0);
    k_stall = 0;
    repeat (8) step();

    // Redirect to 0x100 with two requests in flight.
    k_lat_min = 3; k_lat_max = 3;
    repeat (6) step();
    k_redir = 100; k_redir_fix = 1'b1;
    step();
    k_redir = 0; k_redir_fix = 1'b0;
    repeat (12) step();

    // Redirects landing on response cycles.
    k_lat_min = 1; k_lat_max = 2; k_redir_rsp = 1'b1;
    repeat (6) step();
    k_redir_rsp = 1'b0;
    repeat (6) step();

    // Memory not ready for five cycles.
    k_ready = 0;
    repeat (5) step();
    k_ready = 100;
    repeat (10) step();

    // Spurious response after a clean reset.
    k_ready = 0;
    for (int i = 0; i < 20 && mem_q.size() > 0; i++) step();
    do_reset(1);
    k_spur = 1'b1;
    step();
    k_spur = 1'b0;
    repeat (4) step();
    check_val("err_sticky", {31'd0, o_rsp_err}, 32'd1);

    // Randomised traffic with a mid-operation reset.
    do_reset(1);
    k_ready = 70; k_stall = 30; k_redir = 4; k_lat_min = 1; k_lat_max = 4;
    repeat (1500) step();
    do_reset(1);
    repeat (1500) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_fetch_queue.md
# rv_fetch_queue

Parametrised instruction-fetch front end for the RV pipeline. It replaces the single-register fetch stage: it issues sequential fetch requests to instruction memory over a valid/ready port with variable response latency, and buffers returned instructions with their PCs in a DEPTH-entry queue. The decode stage pulls entries under its own stall signal. A redirect from writeback flushes the queue and discards in-flight responses.

## Interface
- PC_RESET, 32'h0000_0000, fetch address after reset
- ADDR_W, 32, PC/address width
- DEPTH, 4, queue entries; power of two, ≥2
- MAX_OUTST, 2, maximum requests in flight, counting stale ones; 1..DEPTH
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- o_req_valid  out  1  fetch request valid
- o_req_addr  out  ADDR_W  fetch address, word aligned
- i_req_ready  in  1  memory accepts request; fire = o_req_valid && i_req_ready
- i_rsp_valid  in  1  in-order response valid; no backpressure
- i_rsp_inst  in  32  returned instruction
- i_redirect  in  1  writeback PC change
- i_redirect_pc  in  ADDR_W  new fetch PC
- i_stall  in  1  decode stalled; pop = o_valid && !i_stall
- o_valid  out  1  queue head valid (replaces o_ce)
- o_inst  out  32  head instruction
- o_pc  out  ADDR_W  head PC
- o_count  out  $clog2(DEPTH+1)  queue occupancy
- o_rsp_err  out  1  sticky: response arrived with no request outstanding

## Operation
- The block is clocked by i_clk with one asynchronous active-low reset, i_rst_n.
- Reset values: o_req_valid=0, o_req_addr=PC_RESET, o_valid=0, o_inst=0, o_pc=PC_RESET, o_count=0, o_rsp_err=0. Internal counters reset to 0 and rsp_pc resets to PC_RESET.
- Counters:
  - outst counts all requests in flight.
  - drop_cnt counts stale requests in flight; drop_cnt ≤ outst.
  - live = outst − drop_cnt.
- Issue rule: o_req_valid = (outst < MAX_OUTST) && (o_count + live < DEPTH) && !i_redirect. This guarantees queue space for every live response.
- On fire, fetch_pc advances by 4. Address arithmetic is modulo 2^ADDR_W, so 0xFFFF_FFFC wraps to 0.
- Response handling:
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {rsp_pc, i_rsp_inst} is pushed and rsp_pc advances by 4.
  - outst decrements on every response.
  - If outst==0, the response is ignored and o_rsp_err is set.
- Redirect, which has priority over everything else:
  - The queue is cleared and the pop is suppressed.
  - fetch_pc and rsp_pc are set to i_redirect_pc.
  - drop_cnt becomes outst minus any response arriving in that cycle; that response is itself discarded.
  - No request fires in a redirect cycle.
- FSM states:
  - RUN: drop_cnt==0.
  - DRAIN: drop_cnt>0. Entered on a redirect with stale requests in flight; returns to RUN when the last stale response arrives. Issue continues in DRAIN under the rules above.
  - A redirect while in DRAIN recomputes drop_cnt from outst.
- Push and pop in the same cycle: o_count is unchanged; the push is allowed even when the queue is full.
- Push into an empty queue: the head is visible the next cycle.

## Timing
- First request: o_req_valid=1 with o_req_addr=PC_RESET in the first cycle after reset deasserts.
- Response at edge t → o_valid=1 with that inst/pc from t+1. Minimum fetch-to-decode latency is 1 cycle after the response.
- Redirect sampled at t:
  - o_valid=0 and o_count=0 at t+1.
  - o_req_addr=i_redirect_pc and o_req_valid may be high at t+1.
- While o_valid && i_stall, o_inst and o_pc hold stable.
- o_req_addr is stable while o_req_valid && !i_req_ready.
- Reset asserted mid-operation: all state clears immediately. Later responses to pre-reset requests are not tracked and set o_rsp_err.

## Structure
- Package rv_fetch_pkg holds:
  - INST_W=32
  - PC_STEP=4
  - NOP instruction constant 32'h0000_0013
  - fetch_state_t enum {RUN, DRAIN}
  - fetch_entry_t struct {pc, inst}
- Sub-module fetch_fifo: synchronous show-ahead FIFO of fetch_entry_t, parametrised by DEPTH, with push, pop, clear, count, empty and full. Top-level logic is issue control, counters, rsp_pc and the FSM.

## Test plan
- Reset release, i_req_ready=1, 1-cycle response latency, i_stall=0 → o_pc sequence 0x0, 0x4, 0x8…; o_valid high continuously from the 3rd cycle.
- i_stall held high, DEPTH=4 → o_count saturates at 4 and o_req_valid drops. The head stays at pc 0x0 until the stall releases.
- With 2 requests outstanding, redirect to 0x100 → both old responses are dropped and DRAIN is exited. First o_valid shows pc 0x100.
- Redirect in the same cycle as a response → that response is discarded; o_count=0 the next cycle.
- i_req_ready=0 for 5 cycles → o_req_addr holds; no pc is skipped afterward.
- Spurious i_rsp_valid after reset with outst=0 → o_rsp_err=1 and stays set; the queue is unchanged.
